delta_adc_tracker: RTL and testbench
====================================

Name: delta_adc_tracker

Overview:
- Consumer end of the sampling strobe in the DeltaADC path.
- On each `sampling_strb` pulse it performs these steps:
  - waits for the DAC and comparator to settle;
  - samples the synchronized comparator bit;
  - steps the tracking DAC code up or down, with adaptive step size and saturation;
  - presents the new code on a valid/ready output port.
- Sits between the strobe generator, the external comparator/DAC pair, and the downstream sample consumer.

Parameters:
- DATA_W, 12, width of the DAC code and of the output sample.
- SETTLE_CYCLES, 4, cycles waited after a strobe before the comparator is sampled; must be ≥ 1.
- STEP_MAX_LOG2, 3, adaptive step is capped at 2^STEP_MAX_LOG2 LSB.

Ports:
- clk  in  1  clock.
- reset  in  1  reset, synchronous, active-high.
- sampling_strb  in  1  single-cycle sampling strobe.
- comp_in  in  1  asynchronous comparator output; 1 = analog input above DAC level.
- dac_code  out  DATA_W  registered code driving the DAC.
- sample_data  out  DATA_W  latest converted code.
- sample_valid  out  1  `sample_data` is valid.
- sample_ready  in  1  downstream accepts the sample.
- overrun  out  1  1-cycle pulse: an unaccepted sample was overwritten.
- missed_strb  out  1  1-cycle pulse: strobe arrived while busy.
- busy  out  1  high in SETTLE or DECIDE.

Behaviour:
- Reset values:
  - `dac_code` = 2^(DATA_W-1) (midscale); `sample_data` = 0; `sample_valid`, `overrun`, `missed_strb` = 0.
  - State = IDLE; step = 1; last_dir = down; synchronizer flops = 0.
  - Reset mid-operation aborts any conversion. No sample is produced for that conversion.
- Comparator synchronization: `comp_in` passes through a 2-flop synchronizer that runs continuously. comp_s is the second-stage output.
- FSM states: IDLE, SETTLE, DECIDE.
  - IDLE: on `sampling_strb`=1, go to SETTLE and load cnt = SETTLE_CYCLES-1.
  - SETTLE: if cnt = 0, go to DECIDE; otherwise decrement cnt.
  - DECIDE: one cycle, then return to IDLE.
- Timing: strobe high in cycle 0 → SETTLE occupies cycles 1..SETTLE_CYCLES → DECIDE in cycle SETTLE_CYCLES+1. `dac_code`, `sample_data` and `sample_valid` update at the end of DECIDE, so they are visible in cycle SETTLE_CYCLES+2.
- DECIDE arithmetic:
  - dir = comp_s (1 = up).
  - If dir = last_dir, step = min(step*2, 2^STEP_MAX_LOG2); otherwise step = 1. The new step is used for this update.
  - Up: `dac_code` = min(code+step, 2^DATA_W-1). Down: `dac_code` = max(code-step, 0).
  - Computation uses DATA_W+1 bits; the code never wraps.
  - last_dir is updated even when the code saturates.
- Output register:
  - A DECIDE completion loads `sample_data` with the new `dac_code` and sets `sample_valid`.
  - `sample_valid` clears on `sample_ready` when no new sample is loading in the same cycle.
  - New sample while `sample_valid`=1 and `sample_ready`=0: data is overwritten, `sample_valid` stays 1, and `overrun` pulses for 1 cycle.
  - New sample with `sample_ready`=1 in the same cycle: the old sample is accepted, the new one loads, `sample_valid` stays 1, no `overrun`.
- Strobe in SETTLE or DECIDE: ignored, not queued. `missed_strb` pulses in the following cycle.
- `busy` = (state != IDLE), combinational from the state register.

Decomposition:
- Package delta_adc_pkg:
  - state enum (IDLE/SETTLE/DECIDE);
  - `midscale` constant function of DATA_W;
  - dir encoding constants DIR_UP = 1, DIR_DOWN = 0.
- One sub-module, sync_2ff: generic 2-flop bit synchronizer, reusable elsewhere in the ADC path.

Test Plan (DATA_W=12, SETTLE_CYCLES=4, STEP_MAX_LOG2=3):
- Reset with `comp_in`=X-free 0, no strobe → `dac_code`=2048, `sample_valid`=0, `busy`=0, no pulses.
- `comp_in`=1, `sample_ready`=1, five strobes 16 cycles apart → samples 2049, 2051, 2055, 2063, 2071. Each `sample_valid` rises exactly 6 cycles after its strobe.
- Continue with `comp_in`=0 for two strobes → 2070, 2068 (step resets to 1, then 2).
- Preload near top (≥ 520 up-strobes with `comp_in`=1) → `dac_code` reaches 4095 and stays there, no wrap. Then `comp_in`=0 → 4094.
- Handshake:
  - `sample_ready`=0, two strobes → second sample overwrites the first, `overrun`=1 for exactly one cycle, `sample_valid` stays 1.
  - `sample_ready`=1 coincident with a new load → no `overrun`.
- Strobe 2 cycles after a previous strobe → `missed_strb` pulses once and only one sample is produced.
- Reset asserted in cycle 2 of SETTLE → state IDLE, `dac_code`=2048, and no `sample_valid` afterwards.

Source files
------------

// File: rtl/delta_adc_pkg.sv
// ----------------------------------------------------------------------------
// delta_adc_pkg : shared types and constants for the DeltaADC tracking path
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package delta_adc_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    DECIDE = 2'd2
  } state_t;

  localparam logic DIR_UP   = 1'b1;
  localparam logic DIR_DOWN = 1'b0;

  function automatic int unsigned midscale(input int unsigned data_w);
    return 32'd1 << (data_w - 1);
  endfunction

endpackage

`default_nettype wire

// File: rtl/sync_2ff.sv
// ----------------------------------------------------------------------------
// sync_2ff : two-flop single-bit synchronizer, free running
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module sync_2ff (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic meta_q, meta_d;
  logic sync_q, sync_d;

  always_comb begin
    meta_d = d;
    sync_d = meta_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
    end
  end

  assign q = sync_q;

endmodule

`default_nettype wire

// File: rtl/delta_adc_tracker.sv
// ----------------------------------------------------------------------------
// delta_adc_tracker : strobe-driven tracking DAC with adaptive step and
// a valid/ready sample output.  Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module delta_adc_tracker
  import delta_adc_pkg::*;
#(
  parameter int DATA_W        = 12,
  parameter int SETTLE_CYCLES = 4,
  parameter int STEP_MAX_LOG2 = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              sampling_strb,
  input  logic              comp_in,
  output logic [DATA_W-1:0] dac_code,
  output logic [DATA_W-1:0] sample_data,
  output logic              sample_valid,
  input  logic              sample_ready,
  output logic              overrun,
  output logic              missed_strb,
  output logic              busy
);

  localparam int CNT_W  = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam int STEP_W = STEP_MAX_LOG2 + 1;

  localparam logic [DATA_W-1:0] CODE_MID = DATA_W'(midscale(DATA_W));
  localparam logic [DATA_W:0]   CODE_TOP = {1'b0, {DATA_W{1'b1}}};
  localparam logic [CNT_W-1:0]  CNT_LOAD = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [STEP_W-1:0] STEP_ONE = STEP_W'(1);
  localparam logic [STEP_W-1:0] STEP_MAX = STEP_ONE << STEP_MAX_LOG2;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [STEP_W-1:0]   step_q, step_d;
  logic                last_dir_q, last_dir_d;
  logic [DATA_W-1:0]   dac_code_q, dac_code_d;
  logic [DATA_W-1:0]   sample_data_q, sample_data_d;
  logic                sample_valid_q, sample_valid_d;
  logic                overrun_q, overrun_d;
  logic                missed_strb_q, missed_strb_d;

  logic                comp_s;
  logic                load;
  logic [STEP_W:0]     step_dbl;
  logic [STEP_W-1:0]   step_next;
  logic [DATA_W:0]     code_sum;
  logic [DATA_W:0]     code_diff;
  logic [DATA_W-1:0]   code_next;

  sync_2ff u_comp_sync (
    .clk   (clk),
    .reset (reset),
    .d     (comp_in),
    .q     (comp_s)
  );

  // Step/code arithmetic is evaluated every cycle; it only commits in DECIDE.
  always_comb begin
    step_dbl = {step_q, 1'b0};
    if (comp_s == last_dir_q) begin
      step_next = (step_dbl > {1'b0, STEP_MAX}) ? STEP_MAX : step_dbl[STEP_W-1:0];
    end else begin
      step_next = STEP_ONE;
    end
    code_sum  = {1'b0, dac_code_q} + (DATA_W+1)'(step_next);
    code_diff = {1'b0, dac_code_q} - (DATA_W+1)'(step_next);
    if (comp_s == DIR_UP) begin
      code_next = (code_sum > CODE_TOP) ? CODE_TOP[DATA_W-1:0] : code_sum[DATA_W-1:0];
    end else begin
      // A borrow into the extra bit means the subtraction went below zero.
      code_next = code_diff[DATA_W] ? '0 : code_diff[DATA_W-1:0];
    end
  end

  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    step_d         = step_q;
    last_dir_d     = last_dir_q;
    dac_code_d     = dac_code_q;
    sample_data_d  = sample_data_q;
    sample_valid_d = sample_valid_q;
    overrun_d      = 1'b0;
    missed_strb_d  = 1'b0;
    load           = 1'b0;

    case (state_q)
      IDLE: begin
        if (sampling_strb) begin
          state_d = SETTLE;
          cnt_d   = CNT_LOAD;
        end
      end
      SETTLE: begin
        missed_strb_d = sampling_strb;
        if (cnt_q == '0) begin
          state_d = DECIDE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      DECIDE: begin
        missed_strb_d = sampling_strb;
        state_d       = IDLE;
        load          = 1'b1;
        step_d        = step_next;
        last_dir_d    = comp_s;
        dac_code_d    = code_next;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (load) begin
      sample_data_d  = code_next;
      sample_valid_d = 1'b1;
      overrun_d      = sample_valid_q & ~sample_ready;
    end else if (sample_ready) begin
      sample_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= IDLE;
      cnt_q          <= '0;
      step_q         <= STEP_ONE;
      last_dir_q     <= DIR_DOWN;
      dac_code_q     <= CODE_MID;
      sample_data_q  <= '0;
      sample_valid_q <= 1'b0;
      overrun_q      <= 1'b0;
      missed_strb_q  <= 1'b0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      step_q         <= step_d;
      last_dir_q     <= last_dir_d;
      dac_code_q     <= dac_code_d;
      sample_data_q  <= sample_data_d;
      sample_valid_q <= sample_valid_d;
      overrun_q      <= overrun_d;
      missed_strb_q  <= missed_strb_d;
    end
  end

  assign dac_code     = dac_code_q;
  assign sample_data  = sample_data_q;
  assign sample_valid = sample_valid_q;
  assign overrun      = overrun_q;
  assign missed_strb  = missed_strb_q;
  assign busy         = (state_q != IDLE);

endmodule

`default_nettype wire

// File: tb/tb_delta_adc_tracker.sv
// ----------------------------------------------------------------------------
// tb_delta_adc_tracker : directed bench for delta_adc_tracker
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_delta_adc_tracker;

  localparam int DATA_W = 12;

  logic              clk;
  logic              reset;
  logic              sampling_strb;
  logic              comp_in;
  logic [DATA_W-1:0] dac_code;
  logic [DATA_W-1:0] sample_data;
  logic              sample_valid;
  logic              sample_ready;
  logic              overrun;
  logic              missed_strb;
  logic              busy;

  int errors = 0;
  int checks = 0;

  delta_adc_tracker #(
    .DATA_W        (DATA_W),
    .SETTLE_CYCLES (4),
    .STEP_MAX_LOG2 (3)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .sampling_strb (sampling_strb),
    .comp_in       (comp_in),
    .dac_code      (dac_code),
    .sample_data   (sample_data),
    .sample_valid  (sample_valid),
    .sample_ready  (sample_ready),
    .overrun       (overrun),
    .missed_strb   (missed_strb),
    .busy          (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic            comp;
    logic [DATA_W-1:0] exp_code;
  } vec_t;

  vec_t vecs [7];

  task automatic check(input string name, input int unsigned act, input int unsigned exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Strobe is high for the cycle ending at the next posedge; returns at the
  // negedge of cycle 1 (first SETTLE cycle).
  task automatic do_strobe();
    sampling_strb = 1'b1;
    @(negedge clk);
    sampling_strb = 1'b0;
  endtask

  initial begin
    int lat;
    int ovr_cnt;
    int drop_cnt;
    int miss_cnt;
    int val_cnt;
    int mono_bad;
    int unsigned last_data;
    int unsigned prev_code;

    vecs[0] = '{1'b1, 12'd2049};
    vecs[1] = '{1'b1, 12'd2051};
    vecs[2] = '{1'b1, 12'd2055};
    vecs[3] = '{1'b1, 12'd2063};
    vecs[4] = '{1'b1, 12'd2071};
    vecs[5] = '{1'b0, 12'd2070};
    vecs[6] = '{1'b0, 12'd2068};

    reset         = 1'b1;
    sampling_strb = 1'b0;
    comp_in       = 1'b0;
    sample_ready  = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    check("reset_dac_code", dac_code, 2048);
    check("reset_sample_data", sample_data, 0);
    check("reset_valid", sample_valid, 0);
    check("reset_busy", busy, 0);
    check("reset_overrun", overrun, 0);
    check("reset_missed", missed_strb, 0);

    // Tracking sequence with ready held high
    for (int i = 0; i < 7; i++) begin
      comp_in = vecs[i].comp;
      repeat (3) @(negedge clk);
      do_strobe();
      if (i == 0) check("busy_in_settle", busy, 1);
      lat = 1;
      while (!sample_valid && lat < 20) begin
        @(negedge clk);
        lat++;
      end
      check($sformatf("vec%0d_latency", i), lat, 6);
      check($sformatf("vec%0d_sample", i), sample_data, vecs[i].exp_code);
      check($sformatf("vec%0d_dac", i), dac_code, vecs[i].exp_code);
      repeat (6) @(negedge clk);
    end

    // Overwrite of an unaccepted sample
    sample_ready = 1'b0;
    repeat (3) @(negedge clk);
    do_strobe();
    lat = 1;
    while (!sample_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    check("hs_first_latency", lat, 6);
    check("hs_first_sample", sample_data, 2064);
    repeat (3) @(negedge clk);
    do_strobe();
    ovr_cnt  = 0;
    drop_cnt = 0;
    for (int k = 0; k < 15; k++) begin
      @(negedge clk);
      if (overrun) ovr_cnt++;
      if (!sample_valid) drop_cnt++;
    end
    check("hs_overrun_pulses", ovr_cnt, 1);
    check("hs_valid_drops", drop_cnt, 0);
    check("hs_overwritten_sample", sample_data, 2056);

    // Ready arrives in the same cycle as a new load
    do_strobe();
    repeat (4) @(negedge clk);
    sample_ready = 1'b1;
    @(negedge clk);
    check("coinc_overrun", overrun, 0);
    check("coinc_valid", sample_valid, 1);
    check("coinc_sample", sample_data, 2048);
    @(negedge clk);
    check("coinc_valid_clears", sample_valid, 0);
    repeat (6) @(negedge clk);

    // Second strobe while busy is dropped
    comp_in = 1'b1;
    repeat (3) @(negedge clk);
    do_strobe();
    @(negedge clk);
    sampling_strb = 1'b1;
    @(negedge clk);
    sampling_strb = 1'b0;
    miss_cnt  = 0;
    val_cnt   = 0;
    last_data = 0;
    for (int k = 0; k < 20; k++) begin
      if (missed_strb) miss_cnt++;
      if (sample_valid) begin
        val_cnt++;
        last_data = sample_data;
      end
      @(negedge clk);
    end
    check("miss_pulses", miss_cnt, 1);
    check("miss_samples", val_cnt, 1);
    check("miss_sample_value", last_data, 2049);

    // Reset during the second SETTLE cycle
    repeat (3) @(negedge clk);
    do_strobe();
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("midrst_busy", busy, 0);
    check("midrst_dac", dac_code, 2048);
    check("midrst_valid", sample_valid, 0);
    val_cnt = 0;
    for (int k = 0; k < 15; k++) begin
      @(negedge clk);
      if (sample_valid) val_cnt++;
    end
    check("midrst_no_sample", val_cnt, 0);
    check("midrst_dac_held", dac_code, 2048);

    // Drive the code into the top rail and hold it there
    comp_in = 1'b1;
    repeat (3) @(negedge clk);
    mono_bad  = 0;
    prev_code = dac_code;
    for (int n = 0; n < 520; n++) begin
      do_strobe();
      repeat (7) @(negedge clk);
      if (dac_code < prev_code) mono_bad++;
      prev_code = dac_code;
    end
    check("top_no_wrap", mono_bad, 0);
    check("top_saturated", dac_code, 4095);
    check("top_sample", sample_data, 4095);

    comp_in = 1'b0;
    repeat (3) @(negedge clk);
    do_strobe();
    repeat (7) @(negedge clk);
    check("top_step_down", dac_code, 4094);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
